inst_enc_wr: RTL and testbench
==============================

Name: inst_enc_wr

Overview:
- Instruction encoder and program writer for the RV32I subset handled by the core's decoder: ADDI, JALR, ADD, LUI, LW, SW.
- Accepts instruction fields (mnemonic, rd, rs1, rs2, imm) over a valid/ready handshake.
- Assembles each into a 32-bit instruction word and writes it sequentially into instruction memory from word address 0.
- Used by the testbench and boot path to load programs without a host-side assembler.

Parameters:
- ADDR_W, 8, instruction-memory word address width. Capacity is 2^ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  synchronous restart: address, count and error cleared
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_op  in  3  0=ADDI 1=JALR 2=ADD 3=LUI 4=LW 5=SW; 6,7 illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  immediate, two's complement, full value (LUI: upper 20 bits in place)
- mem_wen  out  1  write request to instruction memory
- mem_addr  out  ADDR_W  word address of the current write
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts the write this cycle
- count  out  ADDR_W+1  words committed since reset/start
- full  out  1  memory filled; no further accepts
- err  out  1  sticky: illegal op or immediate out of range seen

Behaviour:
- FSM states IDLE, WRITE, FULL.
- Reset (async) and start (sync): state=IDLE, mem_addr=0, count=0, err=0, mem_wen=0, mem_wdata=0, full=0.
- start has priority over every other event, including a pending write; that write is discarded.
- in_ready = (state==IDLE) && !start. A transfer occurs when in_valid && in_ready.

Encoding of an accepted bundle (registered, so the word appears on mem_wdata the next cycle):
- ADDI: imm[11:0]|rs1|000|rd|0010011
- JALR: imm[11:0]|rs1|000|rd|1100111
- ADD: 0000000|rs2|rs1|000|rd|0110011; imm ignored
- LW: imm[11:0]|rs1|010|rd|0000011
- SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011
- LUI: imm[31:12]|rd|0110111

Validation:
- I/S-type: in_imm[31:11] must be all equal, i.e. -2048..2047.
- LUI: in_imm[11:0] must be 0.
- Illegal op or failed range check: bundle is consumed, err set, no write, state stays IDLE, mem_addr and count unchanged.

IDLE -> WRITE:
- On a valid transfer; mem_wen=1 from the next cycle.

WRITE:
- mem_wen, mem_addr and mem_wdata are held stable until mem_ready is sampled high.
- On acceptance: count+1, mem_addr+1 (wraps modulo 2^ADDR_W).
- If the accepted address was 2^ADDR_W-1, go to FULL; otherwise go to IDLE.
- mem_ready is ignored when mem_wen=0.

FULL:
- full=1, in_ready=0, mem_wen=0, mem_addr=0, count=2^ADDR_W. Left only by start or rst.

Timing:
- Minimum latency: accept at cycle N, mem_wen high at N+1; with mem_ready=1, back in IDLE at N+2.
- Peak throughput: one word per 2 cycles.
- rst asserted mid-WRITE: mem_wen drops immediately (async); no partial commit.

Optional Feature:
- Macro INST_ENC_WR_CSUM_EN.
- Defined: adds output port csum (32 bits), the XOR of every word committed (mem_wen && mem_ready). Cleared to 0 by rst and by start. Updated on the same edge that increments count.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- ADDI rd=1 rs1=0 imm=5, mem_ready=1 -> mem_wen for one cycle, mem_addr=0, mem_wdata=0x00500093; count=1.
- SW rs2=2 rs1=1 imm=-4 -> mem_wdata=0xFE20AE23. LUI rd=5 imm=0x12345000 -> 0x123452B7 at the next address.
- ADDI imm=4096 and in_op=7 -> no mem_wen, err=1, count unchanged. Following valid bundle still written; err stays 1 until start pulses, then err=0 and count=0.
- mem_ready held 0 for 3 cycles during WRITE -> mem_wen, mem_addr and mem_wdata stable and in_ready=0 throughout; commit on the 4th cycle.
- ADDR_W=2, four writes -> full=1, count=4, mem_addr=0, in_ready=0 while in_valid=1. start -> full=0, count=0. rst asserted mid-WRITE -> mem_wen=0 immediately, count=0.
- With INST_ENC_WR_CSUM_EN: words 0x00500093 and 0xFE20AE23 committed -> csum=0xFE70AEB0; start -> csum=0.

Source files
------------

// File: rtl/inst_enc_wr_if.sv
// inst_enc_wr_if -- field-bundle handshake and instruction-memory write bus.
//   in_valid/in_ready : bundle handshake; in_op/in_rd/in_rs1/in_rs2/in_imm fields
//   mem_wen/mem_addr/mem_wdata : write request, held until mem_ready
//   mem_ready : memory accepts the write this cycle
// master = producer of bundles and memory model; slave = the encoder.
interface inst_enc_wr_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_enc_wr.sv
// inst_enc_wr -- RV32I subset encoder (ADDI, JALR, ADD, LUI, LW, SW) that
// writes encoded words sequentially into instruction memory from address 0.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : synchronous restart (address, count, err cleared; pending write dropped)
//   bus        : inst_enc_wr_if.slave (bundle handshake + memory write bus)
//   count      : words committed since reset/start (ADDR_W+1 bits)
//   full       : memory filled, no further accepts until start/rst
//   err        : sticky illegal-op / immediate-range flag
//   csum       : (only with INST_ENC_WR_CSUM_EN) XOR of all committed words
// Optional feature macro: INST_ENC_WR_CSUM_EN
module inst_enc_wr #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    inst_enc_wr_if.slave      bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
`ifdef INST_ENC_WR_CSUM_EN
    output logic [31:0]       csum,
`endif
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
`ifdef INST_ENC_WR_CSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic [31:0] enc_word;
    logic        enc_ok;
    logic        imm12_ok;

    // Encoder: enc_ok folds together op legality and the immediate range check.
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        // I/S immediates are 12-bit signed: bits 31..11 must be a pure sign extension.
        imm12_ok = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
        case (bus.in_op)
            3'd0: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b0010011};
                enc_ok   = imm12_ok;
            end
            3'd1: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b1100111};
                enc_ok   = imm12_ok;
            end
            3'd2: begin
                enc_word = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, 7'b0110011};
                enc_ok   = 1'b1;
            end
            3'd3: begin
                enc_word = {bus.in_imm[31:12], bus.in_rd, 7'b0110111};
                enc_ok   = (bus.in_imm[11:0] == 12'd0);
            end
            3'd4: begin
                enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
                enc_ok   = imm12_ok;
            end
            3'd5: begin
                enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010,
                            bus.in_imm[4:0], 7'b0100011};
                enc_ok   = imm12_ok;
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        full_d  = full_q;
        err_d   = err_q;
`ifdef INST_ENC_WR_CSUM_EN
        csum_d  = csum_q;
`endif
        if (start) begin
            // Restart wins over everything, including an unacknowledged write.
            state_d = IDLE;
            addr_d  = '0;
            count_d = '0;
            wen_d   = 1'b0;
            wdata_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
`ifdef INST_ENC_WR_CSUM_EN
            csum_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (enc_ok) begin
                            wdata_d = enc_word;
                            wen_d   = 1'b1;
                            state_d = WRITE;
                        end else begin
                            // Bad bundle is consumed but never written.
                            err_d = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        wen_d   = 1'b0;
                        count_d = count_q + CNT_ONE;
                        addr_d  = addr_q + ADDR_ONE;   // last address wraps to 0
`ifdef INST_ENC_WR_CSUM_EN
                        csum_d  = csum_q ^ wdata_q;
`endif
                        if (addr_q == '1) begin
                            state_d = FULL;
                            full_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                FULL: begin
                    // Parked until start or rst.
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INST_ENC_WR_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            full_q  <= full_d;
            err_q   <= err_d;
`ifdef INST_ENC_WR_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !start;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign count         = count_q;
    assign full          = full_q;
    assign err           = err_q;
`ifdef INST_ENC_WR_CSUM_EN
    assign csum          = csum_q;
`endif
endmodule

// File: tb/tb_inst_enc_wr.sv
// tb_inst_enc_wr -- directed bench for inst_enc_wr with a write scoreboard.
// Stimulus pushes {address, word} for every legal bundle; a negedge monitor
// pops and compares whenever the DUT commits a write (mem_wen && mem_ready).
module tb_inst_enc_wr;
    localparam int AW = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [AW:0] count;
    logic full;
    logic err;
`ifdef INST_ENC_WR_CSUM_EN
    logic [31:0] csum;
`endif

    inst_enc_wr_if #(.ADDR_W(AW)) bus ();

    inst_enc_wr #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus.slave),
        .count (count),
        .full  (full),
`ifdef INST_ENC_WR_CSUM_EN
        .csum  (csum),
`endif
        .err   (err)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    logic [AW-1:0] exp_addr;
    int            vectors = 0;
    int            miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a commit happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && !start && bus.mem_wen && bus.mem_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("wr_data", bus.mem_wdata, e.word);
            end
        end
    end

    // Drive one bundle (caller sits #1 after a rising edge); returns #1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic legal, input logic [31:0] word);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else if (legal) begin
            exp_q.push_back('{addr: exp_addr, word: word});
            exp_addr = exp_addr + 1'b1;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        chk("in_ready_during_start", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        exp_addr      = '0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.mem_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wen",   32'(bus.mem_wen),   32'd0);
        chk("rst_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_wdata", bus.mem_wdata,      32'd0);
        chk("rst_count", 32'(count),         32'd0);
        chk("rst_full",  32'(full),          32'd0);
        chk("rst_err",   32'(err),           32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ADDI x1, x0, 5: minimum-latency single write
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
        @(negedge clk);
        chk("addi_wen_hi",   32'(bus.mem_wen),  32'd1);
        chk("addi_busy",     32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("addi_wen_lo",   32'(bus.mem_wen),  32'd0);
        chk("addi_count",    32'(count),        32'd1);
        chk("addi_next_adr", 32'(bus.mem_addr), 32'd1);
        chk("addi_ready",    32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // SW x2, -4(x1); LUI x5, 0x12345
        send(3'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20AE23);
        settle();
        send(3'd3, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h123452B7);
        settle();
        chk("three_count", 32'(count), 32'd3);

        // Out-of-range immediate, then illegal op
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 32'd0);
        @(negedge clk);
        chk("bad_imm_no_wen", 32'(bus.mem_wen), 32'd0);
        chk("bad_imm_err",    32'(err),         32'd1);
        @(posedge clk);
        #1;
        send(3'd7, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        chk("bad_op_no_wen", 32'(bus.mem_wen), 32'd0);
        chk("bad_op_count",  32'(count),       32'd3);
        @(posedge clk);
        #1;

        // ADD x3, x1, x2 (imm ignored) fills the last address
        send(3'd2, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 1'b1, 32'h002081B3);
        settle();
        chk("full_flag",  32'(full),         32'd1);
        chk("full_count", 32'(count),        32'd4);
        chk("full_addr",  32'(bus.mem_addr), 32'd0);
        chk("err_sticky", 32'(err),          32'd1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_no_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        pulse_start();
        @(negedge clk);
        chk("start_full",  32'(full),         32'd0);
        chk("start_count", 32'(count),        32'd0);
        chk("start_err",   32'(err),          32'd0);
        chk("start_addr",  32'(bus.mem_addr), 32'd0);
        @(posedge clk);
        #1;

        // JALR x1, -2048(x2) with memory stalled for 3 cycles
        bus.mem_ready = 1'b0;
        send(3'd1, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800, 1'b1, 32'h800100E7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wen",   32'(bus.mem_wen),   32'd1);
            chk("stall_addr",  32'(bus.mem_addr),  32'd0);
            chk("stall_wdata", bus.mem_wdata,      32'h800100E7);
            chk("stall_ready", 32'(bus.in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("stall_no_commit_yet", 32'(count), 32'd0);
        @(negedge clk);
        chk("stall_commit_count", 32'(count),       32'd1);
        chk("stall_commit_wen",   32'(bus.mem_wen), 32'd0);
        @(posedge clk);
        #1;

        // LW x6, 2047(x2): top of immediate range
        send(3'd4, 5'd6, 5'd2, 5'd0, 32'd2047, 1'b1, 32'h7FF12303);
        settle();
        chk("lw_count", 32'(count), 32'd2);

        // LUI with nonzero low bits is rejected
        send(3'd3, 5'd1, 5'd0, 5'd0, 32'h0000_0001, 1'b0, 32'd0);
        settle();
        chk("lui_low_err",   32'(err),   32'd1);
        chk("lui_low_count", 32'(count), 32'd2);

        // Async reset in the middle of a stalled write
        bus.mem_ready = 1'b0;
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
        @(negedge clk);
        chk("pre_rst_wen", 32'(bus.mem_wen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_wen",   32'(bus.mem_wen),  32'd0);
        chk("async_rst_count", 32'(count),        32'd0);
        chk("async_rst_addr",  32'(bus.mem_addr), 32'd0);
        void'(exp_q.pop_back());
        exp_addr = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("async_rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

`ifdef INST_ENC_WR_CSUM_EN
        send(3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
        settle();
        send(3'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20AE23);
        settle();
        chk("csum_two", csum, 32'hFE70AEB0);
        pulse_start();
        @(negedge clk);
        chk("csum_start", csum, 32'd0);
        @(posedge clk);
        #1;
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
